// File: rtl/regfile_wb_port_if.sv
// Writeback/decode-side bundle for regfile_wb_port: W-stage commit inputs,
// D-stage read/issue inputs, and the combinational read data / stall results.
interface regfile_wb_port_if #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 3
);
  logic              RegWriteW;
  logic              MemToRegW;
  logic [DATA_W-1:0] MemReadDataW;
  logic [DATA_W-1:0] alu_resultW;
  logic [ADDR_W-1:0] WriteRegW;
  logic [ADDR_W-1:0] RA1D;
  logic [ADDR_W-1:0] RA2D;
  logic              RE1D;
  logic              RE2D;
  logic [DATA_W-1:0] RD1D;
  logic [DATA_W-1:0] RD2D;
  logic              IssueD;
  logic [ADDR_W-1:0] DestD;
  logic              StallD;
  logic [15:0]       RetireCount;
  logic              ScoreErr;

  modport master (
    output RegWriteW, MemToRegW, MemReadDataW, alu_resultW, WriteRegW,
    output RA1D, RA2D, RE1D, RE2D, IssueD, DestD,
    input  RD1D, RD2D, StallD, RetireCount, ScoreErr
  );

  modport slave (
    input  RegWriteW, MemToRegW, MemReadDataW, alu_resultW, WriteRegW,
    input  RA1D, RA2D, RE1D, RE2D, IssueD, DestD,
    output RD1D, RD2D, StallD, RetireCount, ScoreErr
  );
endinterface

// File: rtl/regfile_wb_port.sv
// Register file + in-flight write scoreboard at MEM/WB; commits at the edge, reads bypass same cycle.
// StallD is combinational from counts and current W inputs; issues offered while stalled are dropped.
module regfile_wb_port #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 3,
  parameter int CNT_W  = 2
) (
  input logic           clk,
  input logic           reset,
  regfile_wb_port_if.slave bus
);
  localparam int NREGS = 2 ** ADDR_W;
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic [DATA_W-1:0] regs [NREGS];
  logic [CNT_W-1:0]  cnt  [NREGS];
  logic [15:0]       retireCount;
  logic              scoreErr;

  logic [DATA_W-1:0] resultW;
  logic              wbEn;
  logic              issueEn;
  logic              hazard1;
  logic              hazard2;
  logic [NREGS-1:0]  incVec;
  logic [NREGS-1:0]  decVec;

  function automatic logic [DATA_W-1:0] readPort(
    input logic [ADDR_W-1:0] ra,
    input logic [DATA_W-1:0] arrVal,
    input logic [DATA_W-1:0] res,
    input logic              wb,
    input logic [ADDR_W-1:0] wr
  );
    if (ra == '0)
      return '0;
    else if (wb && (wr == ra))
      return res;
    else
      return arrVal;
  endfunction

  // A single pending write that retires this very cycle is covered by bypass.
  function automatic logic hazard(
    input logic              re,
    input logic [ADDR_W-1:0] ra,
    input logic [CNT_W-1:0]  c,
    input logic              wb,
    input logic [ADDR_W-1:0] wr
  );
    return re && (ra != '0) && (c != '0) &&
           !((c == CNT_W'(1)) && wb && (wr == ra));
  endfunction

  assign resultW = bus.MemToRegW ? bus.MemReadDataW : bus.alu_resultW;
  assign wbEn    = bus.RegWriteW && (bus.WriteRegW != '0);

  assign hazard1 = hazard(bus.RE1D, bus.RA1D, cnt[bus.RA1D], wbEn, bus.WriteRegW);
  assign hazard2 = hazard(bus.RE2D, bus.RA2D, cnt[bus.RA2D], wbEn, bus.WriteRegW);
  assign issueEn = bus.IssueD && !(hazard1 || hazard2) && (bus.DestD != '0);

  assign bus.RD1D        = readPort(bus.RA1D, regs[bus.RA1D], resultW, wbEn, bus.WriteRegW);
  assign bus.RD2D        = readPort(bus.RA2D, regs[bus.RA2D], resultW, wbEn, bus.WriteRegW);
  assign bus.StallD      = hazard1 || hazard2;
  assign bus.RetireCount = retireCount;
  assign bus.ScoreErr    = scoreErr;

  always_comb begin
    incVec = '0;
    decVec = '0;
    if (issueEn)
      incVec[bus.DestD] = 1'b1;
    if (wbEn)
      decVec[bus.WriteRegW] = 1'b1;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int r = 0; r < NREGS; r++) begin
        regs[r] <= '0;
        cnt[r]  <= '0;
      end
      retireCount <= '0;
      scoreErr    <= 1'b0;
    end else begin
      if (wbEn) begin
        regs[bus.WriteRegW] <= resultW;
        retireCount         <= retireCount + 16'd1;
      end
      // Simultaneous issue and retire of one register cancel out.
      for (int r = 1; r < NREGS; r++) begin
        if (incVec[r] && !decVec[r]) begin
          if (cnt[r] == CNT_MAX)
            scoreErr <= 1'b1;
          else
            cnt[r] <= cnt[r] + 1'b1;
        end else if (decVec[r] && !incVec[r]) begin
          if (cnt[r] == '0)
            scoreErr <= 1'b1;
          else
            cnt[r] <= cnt[r] - 1'b1;
        end
      end
    end
  end
endmodule

// File: tb/tb_regfile_wb_port.sv
// Randomised + directed bench for regfile_wb_port with a queue-based scoreboard
// fed by an arithmetic reference model of registers and pending-write counts.
module tb_regfile_wb_port;
  localparam int DW   = 16;
  localparam int AW   = 3;
  localparam int CW   = 2;
  localparam int NR   = 8;
  localparam int CMAX = 3;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  regfile_wb_port_if #(.DATA_W(DW), .ADDR_W(AW)) bus ();

  regfile_wb_port #(.DATA_W(DW), .ADDR_W(AW), .CNT_W(CW)) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  typedef struct {
    bit rstn, rw, mtr, re1, re2, iss;
    int md, alu, wr, ra1, ra2, dest;
  } stim_t;

  typedef struct {
    logic [15:0] rd1, rd2, retire;
    logic        stall, err;
  } exp_t;

  exp_t q[$];
  int   nTests = 0;
  int   nFail  = 0;

  int mRegs[NR];
  int mCnt[NR];
  int mRetire;
  bit mErr;

  function automatic stim_t nop();
    stim_t s;
    s = '{rstn: 1, rw: 0, mtr: 0, re1: 0, re2: 0, iss: 0,
          md: 0, alu: 0, wr: 0, ra1: 0, ra2: 0, dest: 0};
    return s;
  endfunction

  task automatic modelReset();
    for (int i = 0; i < NR; i++) begin
      mRegs[i] = 0;
      mCnt[i]  = 0;
    end
    mRetire = 0;
    mErr    = 0;
  endtask

  // Drive one cycle, queue its expected outputs, then advance the model past the edge.
  task automatic step(input stim_t s);
    exp_t e;
    int   res, p1, p2, delta, n;
    bit   wb, stall;
    reset = s.rstn;
    if (!s.rstn) modelReset();
    bus.RegWriteW    = s.rw;
    bus.MemToRegW    = s.mtr;
    bus.MemReadDataW = DW'(s.md);
    bus.alu_resultW  = DW'(s.alu);
    bus.WriteRegW    = AW'(s.wr);
    bus.RA1D         = AW'(s.ra1);
    bus.RA2D         = AW'(s.ra2);
    bus.RE1D         = s.re1;
    bus.RE2D         = s.re2;
    bus.IssueD       = s.iss;
    bus.DestD        = AW'(s.dest);

    res = (s.mtr ? s.md : s.alu) & 16'hFFFF;
    wb  = s.rw && (s.wr != 0);
    e.rd1 = (s.ra1 == 0) ? 16'd0 : (wb && s.wr == s.ra1) ? 16'(res) : 16'(mRegs[s.ra1]);
    e.rd2 = (s.ra2 == 0) ? 16'd0 : (wb && s.wr == s.ra2) ? 16'(res) : 16'(mRegs[s.ra2]);
    // Writes still outstanding once this cycle's writeback is counted.
    p1 = mCnt[s.ra1] - ((wb && s.wr == s.ra1) ? 1 : 0);
    p2 = mCnt[s.ra2] - ((wb && s.wr == s.ra2) ? 1 : 0);
    stall = (s.re1 && s.ra1 != 0 && p1 > 0) || (s.re2 && s.ra2 != 0 && p2 > 0);
    e.stall  = stall;
    e.retire = 16'(mRetire);
    e.err    = mErr;
    q.push_back(e);

    @(posedge clk);
    #1;
    if (s.rstn) begin
      if (wb) begin
        mRegs[s.wr] = res;
        mRetire     = (mRetire + 1) % 65536;
      end
      for (int r = 1; r < NR; r++) begin
        delta = ((s.iss && !stall && s.dest == r) ? 1 : 0) - ((wb && s.wr == r) ? 1 : 0);
        n = mCnt[r] + delta;
        if (n < 0 || n > CMAX) mErr = 1;
        else mCnt[r] = n;
      end
    end
  endtask

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    nTests++;
    if (act !== exp) begin
      nFail++;
      $display("FAIL %s: got 0x%04h expected 0x%04h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (q.size() > 0) begin
      e = q.pop_front();
      check("RD1D", bus.RD1D, e.rd1);
      check("RD2D", bus.RD2D, e.rd2);
      check("StallD", {15'd0, bus.StallD}, {15'd0, e.stall});
      check("RetireCount", bus.RetireCount, e.retire);
      check("ScoreErr", {15'd0, bus.ScoreErr}, {15'd0, e.err});
    end
  end

  initial begin
    stim_t s;
    reset = 1'b0;
    modelReset();
    s = nop();
    step_init: begin
      @(posedge clk);
      #1;
    end
    s.rstn = 0; step(s); step(s);
    s = nop(); s.ra1 = 1; s.ra2 = 2; s.re1 = 1; s.re2 = 1; step(s);

    // ALU writeback to R3 with same-cycle bypass, then array read.
    s = nop(); s.rw = 1; s.alu = 16'h1234; s.wr = 3; s.ra1 = 3; step(s);
    s = nop(); s.ra1 = 3; step(s);
    // Load data aimed at R0 is dropped.
    s = nop(); s.rw = 1; s.mtr = 1; s.md = 16'hBEEF; s.wr = 0; s.ra1 = 0; step(s);
    s = nop(); s.ra1 = 0; s.ra2 = 3; step(s);

    // Single pending write to R5 stalls until its writeback.
    s = nop(); s.iss = 1; s.dest = 5; step(s);
    s = nop(); s.ra1 = 5; s.re1 = 1; step(s); step(s);
    s.rw = 1; s.alu = 16'h5A5A; s.wr = 5; step(s);
    s = nop(); s.ra1 = 5; s.re1 = 1; step(s);

    // Two pending writes to R4.
    s = nop(); s.iss = 1; s.dest = 4; step(s); step(s);
    s = nop(); s.rw = 1; s.alu = 16'h4444; s.wr = 4; s.ra1 = 4; s.re1 = 1; step(s);
    s.alu = 16'h4445; step(s);
    s = nop(); s.ra1 = 4; s.re1 = 1; step(s);
    s = nop(); s.iss = 1; s.dest = 4; step(s);
    s = nop(); s.iss = 1; s.dest = 4; s.rw = 1; s.alu = 16'h4446; s.wr = 4; step(s);
    s = nop(); s.ra2 = 4; s.re2 = 1; step(s);
    s.rw = 1; s.alu = 16'h4447; s.wr = 4; step(s);
    s = nop(); s.ra2 = 4; s.re2 = 1; step(s);

    // Overflow on R6, then reset clears the sticky error.
    s = nop(); s.iss = 1; s.dest = 6;
    repeat (4) step(s);
    s = nop(); s.ra1 = 6; s.re1 = 1; step(s);
    s = nop(); s.rstn = 0; step(s);
    // Underflow on R7: error raised, data still written.
    s = nop(); s.rw = 1; s.alu = 16'h7777; s.wr = 7; step(s);
    s = nop(); s.ra1 = 7; s.ra2 = 7; s.re1 = 1; step(s);
    s = nop(); s.rstn = 0; step(s);

    for (int i = 0; i < 800; i++) begin
      s = nop();
      s.rstn = ($urandom_range(0, 99) != 0);
      s.rw   = $urandom_range(0, 2) == 0;
      s.mtr  = $urandom_range(0, 1);
      s.md   = $urandom_range(0, 16'hFFFF);
      s.alu  = $urandom_range(0, 16'hFFFF);
      s.wr   = $urandom_range(0, NR - 1);
      s.ra1  = $urandom_range(0, NR - 1);
      s.ra2  = $urandom_range(0, NR - 1);
      s.re1  = $urandom_range(0, 1);
      s.re2  = $urandom_range(0, 1);
      s.iss  = $urandom_range(0, 2) == 0;
      s.dest = $urandom_range(0, NR - 1);
      step(s);
    end

    repeat (2) @(negedge clk);
    nTests++;
    if (q.size() != 0) begin
      nFail++;
      $display("FAIL scoreboard_drain: %0d entries left, expected 0", q.size());
    end
    $display("[TB] %0d tests run, %0d failed", nTests, nFail);
    $finish;
  end
endmodule

// File: doc/regfile_wb_port.md
# regfile_wb_port

Register file plus in-flight write scoreboard forming the consumer end of the MEM/WB pipeline register. It selects the writeback value (memory data or ALU result), commits it to the register array, and serves the decode stage's two read ports with same-cycle write bypass. It also tracks issued-but-unretired destinations per register and raises a decode stall on a read-after-write hazard that bypass cannot cover.

## Interface
- DATA_W, 16, register/data width
- ADDR_W, 3, register address width; NREGS = 2**ADDR_W
- CNT_W, 2, width of per-register in-flight counter (max 2**CNT_W-1 pending writes)

- clk  in  1  clock, rising edge
- reset  in  1  asynchronous, active-low
- RegWriteW  in  1  writeback enable from the MEM/WB register
- MemToRegW  in  1  1: write MemReadDataW, 0: write alu_resultW
- MemReadDataW  in  DATA_W  load data
- alu_resultW  in  DATA_W  ALU result
- WriteRegW  in  ADDR_W  destination register
- RA1D, RA2D  in  ADDR_W  decode read addresses
- RE1D, RE2D  in  1  read port actually used by the instruction (hazard qualifier)
- RD1D, RD2D  out  DATA_W  read data
- IssueD  in  1  instruction leaves decode with a register write
- DestD  in  ADDR_W  its destination
- StallD  out  1  decode must hold
- RetireCount  out  16  count of committed writes, wraps
- ScoreErr  out  1  sticky scoreboard over/underflow flag

## Operation
- ResultW = MemToRegW ? MemReadDataW : alu_resultW.
- Commit: on a rising edge with RegWriteW=1 and WriteRegW!=0, regs[WriteRegW] <= ResultW; RetireCount increments (0xFFFF -> 0x0000). R0 writes are dropped and not counted.
- Reads: RDn = 0 if RAn=0; else ResultW if RegWriteW and WriteRegW==RAn (bypass); else regs[RAn].
- Scoreboard: cnt[r] per register r=1..NREGS-1; cnt[0] constant 0.
  - inc = IssueD && !StallD && DestD!=0; dec = RegWriteW && WriteRegW!=0.
  - inc and dec on the same register in the same cycle: count unchanged.
  - inc with cnt at max: count holds, ScoreErr <= 1.
  - dec with cnt 0: count holds at 0, data write still performed, ScoreErr <= 1.
- Hazard for port n: REn && RAn!=0 && cnt[RAn]!=0 && !(cnt[RAn]==1 && RegWriteW && WriteRegW==RAn).
- StallD = hazard1 | hazard2. IssueD is ignored (not counted) while StallD=1.
- ScoreErr clears only on reset.

## Timing
- Reset (asynchronous, active-low): all regs = 0, all cnt = 0, RetireCount = 0, ScoreErr = 0. Outputs during reset: RD1D/RD2D = 0 unless bypass is active (combinational on inputs), StallD = 0.
- Write latency: committed at the rising edge; visible through the array the cycle after, and through bypass in the same cycle.
- StallD, RD1D and RD2D are combinational from the current cnt/regs state and the current W/D inputs. No registered output path except RetireCount and ScoreErr.
- Scoreboard updates take effect at the rising edge, so a stall caused by cnt==1 drops in the cycle whose writeback retires that register.
- Reset asserted mid-stream discards all pending counts. The pipeline registers reset in the same event, so there are no stale retirements.

## Test plan
- Reset, then read R1/R2 -> RD1D=RD2D=0, StallD=0, RetireCount=0, ScoreErr=0.
- RegWriteW=1, MemToRegW=0, alu_resultW=0x1234, WriteRegW=3, RA1D=3 in the same cycle -> RD1D=0x1234 (bypass); next cycle, with RegWriteW=0 -> RD1D=0x1234, RetireCount=1.
- MemToRegW=1, MemReadDataW=0xBEEF, WriteRegW=0 -> R0 reads 0 and RetireCount is unchanged.
- Sequence:
  - IssueD DestD=5.
  - Next cycle RA1D=5, RE1D=1 -> StallD=1.
  - Hold until RegWriteW with WriteRegW=5 -> StallD=0 that cycle, RD1D=written value, cnt[5]=0 after the edge.
- Two issues to R4 (cnt=2), then writeback R4 -> StallD stays 1 for RA1D=4. After the second writeback -> StallD=0. Same-cycle issue and writeback of R4 leaves cnt unchanged.
- Overflow/underflow: four issues to R6 with CNT_W=2 -> cnt=3, ScoreErr=1. Separately, writeback R7 with cnt=0 -> ScoreErr=1 and data written. Then reset -> ScoreErr=0.
